// File: rtl/morph_pkg.sv
// Shared types and sizing helpers for the streaming binary morphology window.
package morph_pkg;

  typedef enum logic {
    MORPH_ERODE  = 1'b0,
    MORPH_DILATE = 1'b1
  } morph_mode_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } morph_state_e;

  // Counter width for a range of n values, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/binary_morph_window_if.sv
// Pixel stream bundle: binarised input stream in, filtered stream and frame markers out.
interface binary_morph_window_if;

  logic mode;
  logic in_valid;
  logic in_sof;
  logic in_pixel;
  logic out_valid;
  logic out_pixel;
  logic out_sof;
  logic out_eol;
  logic frame_done;
  logic frame_abort;

  modport master (
    output mode, in_valid, in_sof, in_pixel,
    input  out_valid, out_pixel, out_sof, out_eol, frame_done, frame_abort
  );

  modport slave (
    input  mode, in_valid, in_sof, in_pixel,
    output out_valid, out_pixel, out_sof, out_eol, frame_done, frame_abort
  );

endinterface

// File: rtl/morph_line_buffer.sv
// One-line 1-bit delay on a circular RAM; the registered read is prefetched one
// enable ahead so o_dout is the sample written DEPTH enables before the current one.
module morph_line_buffer
  import morph_pkg::*;
#(
  parameter int DEPTH = 488
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  input  logic i_din,
  output logic o_dout
);

  localparam int AW = cnt_width(DEPTH);

  logic          r_mem [DEPTH];
  logic [AW-1:0] r_ptr;
  logic [AW-1:0] w_ptr_next;
  logic          r_dout;

  assign w_ptr_next = (r_ptr == AW'(DEPTH - 1)) ? '0 : r_ptr + 1'b1;
  assign o_dout     = r_dout;

  always_ff @(posedge clk) begin
    if (i_en) begin
      r_mem[r_ptr] <= i_din;
    end
  end

  // Reading the slot the next write will overwrite keeps this a simple-dual-port RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr  <= '0;
      r_dout <= 1'b0;
    end else if (i_en) begin
      r_ptr  <= w_ptr_next;
      r_dout <= r_mem[w_ptr_next];
    end
  end

endmodule

// File: rtl/binary_morph_window.sv
// Streaming K x K binary erode/dilate over a raster 1-bit image, valid region only,
// with frame/row markers on the output stream.
module binary_morph_window
  import morph_pkg::*;
#(
  parameter int IMG_W = 488,
  parameter int IMG_H = 302,
  parameter int K     = 5
) (
  input  logic                  clk_out,
  input  logic                  rst_n,
  binary_morph_window_if.slave  bus
);

  localparam int CW = cnt_width(IMG_W);
  localparam int RW = cnt_width(IMG_H);

  morph_state_e   r_state;
  morph_mode_e    r_mode;
  logic [CW-1:0]  r_col;
  logic [RW-1:0]  r_row;
  logic           r_out_valid;
  logic           r_out_pixel;
  logic           r_out_sof;
  logic           r_out_eol;
  logic           r_frame_done;
  logic           r_frame_abort;

  logic           w_sof;
  logic           w_accept;
  logic [CW-1:0]  w_cur_col;
  logic [RW-1:0]  w_cur_row;
  logic           w_last_col;
  logic           w_last_row;
  logic           w_in_region;
  logic [K-1:0]   w_tap;
  logic [K-2:0]   r_win [K];
  logic [K-1:0]   w_row [K];
  logic           w_and;
  logic           w_or;

  // An SOF pixel is accepted in any state and is always position (0,0).
  assign w_sof       = bus.in_valid & bus.in_sof;
  assign w_accept    = bus.in_valid & (bus.in_sof | (r_state == ST_ACTIVE));
  assign w_cur_col   = bus.in_sof ? '0 : r_col;
  assign w_cur_row   = bus.in_sof ? '0 : r_row;
  assign w_last_col  = (w_cur_col == CW'(IMG_W - 1));
  assign w_last_row  = (w_cur_row == RW'(IMG_H - 1));
  assign w_in_region = (w_cur_row >= RW'(K - 1)) && (w_cur_col >= CW'(K - 1));

  assign w_tap[0] = bus.in_pixel;

  generate
    for (genvar g = 1; g < K; g++) begin : g_lb
      morph_line_buffer #(
        .DEPTH (IMG_W)
      ) u_lb (
        .clk    (clk_out),
        .rst_n  (rst_n),
        .i_en   (w_accept),
        .i_din  (w_tap[g-1]),
        .o_dout (w_tap[g])
      );
    end
  endgenerate

  always_comb begin
    w_and = 1'b1;
    w_or  = 1'b0;
    for (int k = 0; k < K; k++) begin
      w_row[k] = {r_win[k], w_tap[k]};
      w_and    = w_and & (&w_row[k]);
      w_or     = w_or  | (|w_row[k]);
    end
  end

  always_ff @(posedge clk_out or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < K; k++) begin
        r_win[k] <= '0;
      end
    end else if (w_accept) begin
      for (int k = 0; k < K; k++) begin
        r_win[k] <= w_row[k][K-2:0];
      end
    end
  end

  // Stale window contents after an abort are harmless: output waits for K-1 new rows.
  always_ff @(posedge clk_out or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_mode        <= MORPH_ERODE;
      r_col         <= '0;
      r_row         <= '0;
      r_out_valid   <= 1'b0;
      r_out_pixel   <= 1'b0;
      r_out_sof     <= 1'b0;
      r_out_eol     <= 1'b0;
      r_frame_done  <= 1'b0;
      r_frame_abort <= 1'b0;
    end else begin
      r_out_valid   <= 1'b0;
      r_out_pixel   <= 1'b0;
      r_out_sof     <= 1'b0;
      r_out_eol     <= 1'b0;
      r_frame_done  <= 1'b0;
      r_frame_abort <= 1'b0;
      if (w_accept) begin
        if (w_sof) begin
          r_mode        <= morph_mode_e'(bus.mode);
          r_frame_abort <= (r_state == ST_ACTIVE);
        end
        if (w_last_col && w_last_row) begin
          r_state <= ST_IDLE;
          r_col   <= '0;
          r_row   <= '0;
        end else begin
          r_state <= ST_ACTIVE;
          r_col   <= w_last_col ? '0 : w_cur_col + 1'b1;
          r_row   <= w_last_col ? w_cur_row + 1'b1 : w_cur_row;
        end
        if (w_in_region) begin
          r_out_valid  <= 1'b1;
          r_out_pixel  <= (r_mode == MORPH_DILATE) ? w_or : w_and;
          r_out_sof    <= (w_cur_row == RW'(K - 1)) && (w_cur_col == CW'(K - 1));
          r_out_eol    <= w_last_col;
          r_frame_done <= w_last_col && w_last_row;
        end
      end
    end
  end

  assign bus.out_valid   = r_out_valid;
  assign bus.out_pixel   = r_out_pixel;
  assign bus.out_sof     = r_out_sof;
  assign bus.out_eol     = r_out_eol;
  assign bus.frame_done  = r_frame_done;
  assign bus.frame_abort = r_frame_abort;

endmodule
